// File: rtl/system_led_pulse_pio.sv
// Avalon-MM output PIO: steady LED register with set/clear access plus a
// shared one-shot pulse overlay that software can trigger and forget.
module system_led_pulse_pio #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned PULSE_RESET = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [2:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_STAT  = 3'd1;
  localparam logic [2:0] A_SET   = 3'd2;
  localparam logic [2:0] A_CLR   = 3'd3;
  localparam logic [2:0] A_PULSE = 3'd4;
  localparam logic [2:0] A_LEN   = 3'd5;

  typedef enum logic {IDLE, ACTIVE} pulse_state_t;

  pulse_state_t         state, state_n;
  logic [WIDTH-1:0]     data_reg;
  logic [WIDTH-1:0]     pulse_mask, pulse_mask_n;
  logic [CNT_WIDTH-1:0] pulse_cnt, pulse_cnt_n;
  logic [CNT_WIDTH-1:0] pulse_len;

  logic                 wr_p0;
  logic [WIDTH-1:0]     wmask_p0;
  logic                 pulse_wr_p0;

  function automatic logic [CNT_WIDTH-1:0] reload_value(input logic [CNT_WIDTH-1:0] len);
    // A zero length still yields a single-cycle pulse.
    return (len == '0) ? '0 : len - CNT_WIDTH'(1);
  endfunction

  function automatic logic [31:0] zext_w(input logic [WIDTH-1:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] zext_c(input logic [CNT_WIDTH-1:0] v);
    return 32'(v);
  endfunction

  assign wr_p0       = chipselect & ~write_n;
  assign wmask_p0    = writedata[WIDTH-1:0];
  assign pulse_wr_p0 = wr_p0 && (address == A_PULSE) && (wmask_p0 != '0);

  assign out_port = data_reg | pulse_mask;

  // Pulse FSM: a PULSE write always wins over expiry, so retriggers never gap.
  always_comb begin
    state_n      = state;
    pulse_mask_n = pulse_mask;
    pulse_cnt_n  = pulse_cnt;
    if (pulse_wr_p0) begin
      state_n      = ACTIVE;
      pulse_mask_n = pulse_mask | wmask_p0;
      pulse_cnt_n  = reload_value(pulse_len);
    end else begin
      case (state)
        ACTIVE: begin
          if (pulse_cnt == '0) begin
            state_n      = IDLE;
            pulse_mask_n = '0;
          end else begin
            pulse_cnt_n = pulse_cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          pulse_mask_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pulse_mask <= '0;
      pulse_cnt  <= '0;
    end else begin
      state      <= state_n;
      pulse_mask <= pulse_mask_n;
      pulse_cnt  <= pulse_cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg  <= '0;
      pulse_len <= CNT_WIDTH'(PULSE_RESET);
    end else if (wr_p0) begin
      case (address)
        A_DATA:  data_reg  <= wmask_p0;
        A_SET:   data_reg  <= data_reg | wmask_p0;
        A_CLR:   data_reg  <= data_reg & ~wmask_p0;
        A_LEN:   pulse_len <= writedata[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Read stage: address is sampled every cycle, independent of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        A_DATA:  readdata <= zext_w(data_reg);
        A_STAT:  readdata <= zext_w(pulse_mask);
        A_LEN:   readdata <= zext_c(pulse_len);
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_system_led_pulse_pio.sv
// Directed bench for system_led_pulse_pio with a queue-based expected-value scoreboard.
module tb_system_led_pulse_pio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  system_led_pulse_pio #(.WIDTH(8), .CNT_WIDTH(24), .PULSE_RESET(5000000)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write_n(write_n),
    .address(address), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp);
    push(tag, {24'd0, exp});
    pop_cmp({24'd0, out_port});
  endtask

  // Caller is at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  // Caller is at a negedge; returns #1 after the capturing edge.
  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    push(tag, exp);
    @(posedge clk); #1;
    pop_cmp(readdata);
  endtask

  initial begin
    #2;
    chk_out("rst_out", 8'h00);
    push("rst_rd", 32'd0); pop_cmp(readdata);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    rd("rd_data0", 3'd0, 32'd0);
    @(negedge clk); rd("rd_stat0", 3'd1, 32'd0);
    @(negedge clk); rd("rd_len0", 3'd5, 32'd5000000);
    @(negedge clk); chk_out("out0", 8'h00);

    // Steady register: load, set, clear
    wr(3'd0, 32'h0000_00A5); chk_out("data_a5", 8'hA5);
    rd("rd_a5", 3'd0, 32'h0000_00A5);
    @(negedge clk); wr(3'd2, 32'h0000_000A); chk_out("set_af", 8'hAF);
    rd("rd_af", 3'd0, 32'h0000_00AF);
    @(negedge clk); wr(3'd3, 32'h0000_0081); chk_out("clr_2e", 8'h2E);
    rd("rd_2e", 3'd0, 32'h0000_002E);
    @(negedge clk); rd("rd_set_wo", 3'd2, 32'd0);
    @(negedge clk); wr(3'd0, 32'hFFFF_FF5A); chk_out("data_hi_drop", 8'h5A);
    rd("rd_hi_drop", 3'd0, 32'h0000_005A);
    @(negedge clk); wr(3'd6, 32'h0000_00FF); chk_out("rsvd_wr", 8'h5A);
    rd("rd_rsvd", 3'd6, 32'd0);

    // Basic 4-cycle pulse
    @(negedge clk); wr(3'd0, 32'd0);
    wr(3'd5, 32'd4);
    rd("rd_len4", 3'd5, 32'd4);
    @(negedge clk); wr(3'd4, 32'h0000_0003);
    address = 3'd1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk_out($sformatf("pulse_hi%0d", i), 8'h03);
      push($sformatf("stat_hi%0d", i), 32'h3);
      @(posedge clk); #1; pop_cmp(readdata);
    end
    @(negedge clk); chk_out("pulse_lo", 8'h00);
    push("stat_lo", 32'h0); @(posedge clk); #1; pop_cmp(readdata);

    // Retrigger exactly in the expiry cycle
    @(negedge clk); wr(3'd4, 32'h0000_0001);
    chk_out("retrig_a0", 8'h01);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); chk_out($sformatf("retrig_a%0d", i), 8'h01);
    end
    wr(3'd4, 32'h0000_0010);
    chk_out("retrig_b0", 8'h11);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); chk_out($sformatf("retrig_b%0d", i), 8'h11);
    end
    @(negedge clk); chk_out("retrig_end", 8'h00);

    // Zero length gives one cycle; zero mask does nothing
    wr(3'd5, 32'd0);
    wr(3'd4, 32'h0000_0080); chk_out("len0_hi", 8'h80);
    @(negedge clk); chk_out("len0_lo", 8'h00);
    wr(3'd4, 32'h0000_0000); chk_out("mask0_out", 8'h00);
    rd("mask0_stat", 3'd1, 32'd0);

    // Asynchronous reset mid-pulse
    @(negedge clk); wr(3'd0, 32'h0000_000F);
    wr(3'd5, 32'd100);
    wr(3'd4, 32'h0000_0030); chk_out("pre_rst", 8'h3F);
    @(posedge clk); #3;
    reset = 1'b1; #1;
    chk_out("async_rst_out", 8'h00);
    push("async_rst_rd", 32'd0); pop_cmp(readdata);
    @(negedge clk); reset = 1'b0;
    rd("post_rst_len", 3'd5, 32'd5000000);
    @(negedge clk); rd("post_rst_data", 3'd0, 32'd0);
    @(negedge clk); rd("post_rst_stat", 3'd1, 32'd0);
    @(negedge clk); chk_out("post_rst_out", 8'h00);

    total++;
    assert (tag_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", tag_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
